// File: rtl/omsp_ps2_fifo.sv
// omsp_ps2_fifo: PS/2 host with RX/TX frame FSMs, RX FIFO and IRQs.
// Optional macro PS2_TIMEOUT_EN adds a clock-loss abort counter.
module omsp_ps2_fifo #(
    parameter logic [14:0] BASE_ADDR   = 15'h00a0,
    parameter int          DEC_WD      = 3,
    parameter int          FIFO_AW     = 3,
    parameter int          INHIBIT_CYC = 2400,
    parameter int          TIMEOUT_CYC = 48000
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        irq_rx,
    output logic        irq_tx,
    input  logic        ps2_clk_i,
    output logic        ps2_clk_oe,
    input  logic        ps2_data_i,
    output logic        ps2_data_oe
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int LW    = FIFO_AW + 1;
    localparam int WA    = DEC_WD - 1;
    localparam int IW    = $clog2(INHIBIT_CYC + 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_INH,
        TX_REQ,
        TX_SEND,
        TX_ACK,
        TX_DONE
    } tx_state_t;

    // bus decode
    logic          reg_sel;
    logic [WA-1:0] reg_off;
    logic          sel_stat;
    logic          sel_data;
    logic          sel_ctrl;
    logic          bus_rd;
    logic          bus_wr;
    logic          stat_wr;
    logic          flush;
    logic          tx_start;
    logic          unused_din;

    // pad synchronisers
    logic [1:0] clk_s;
    logic       clk_q;
    logic [1:0] dat_s;
    logic       fall;
    logic       din;

    // control and sticky flags
    logic rx_ie;
    logic tx_ie;
    logic ovf;
    logic rx_err;
    logic tx_nack;
    logic tx_done;

    // fifo
    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [LW-1:0]      level;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;

    // rx
    rx_state_t  rx_state;
    rx_state_t  rx_next;
    logic [7:0] rx_sh;
    logic [2:0] rx_cnt;
    logic       rx_par;
    logic       rx_shift;
    logic       rx_par_ld;
    logic       rx_good;
    logic       rx_bad;

    // tx
    tx_state_t  tx_state;
    tx_state_t  tx_next;
    logic [7:0] tx_sh;
    logic       tx_par;
    logic [3:0] tx_cnt;
    logic [IW-1:0] inh_cnt;
    logic       tx_do;
    logic       tx_do_nxt;
    logic       tx_shift;
    logic       tx_cnt_inc;
    logic       tx_busy;
    logic       nack_ack;
    logic       tx_abort;

    logic       to_hit;

    assign reg_sel  = per_en
                    & (per_addr[13:WA] == BASE_ADDR[14:DEC_WD]);
    assign reg_off  = per_addr[WA-1:0];
    assign sel_stat = reg_sel & (reg_off == WA'(0));
    assign sel_data = reg_sel & (reg_off == WA'(1));
    assign sel_ctrl = reg_sel & (reg_off == WA'(2));
    assign bus_rd   = ~|per_we;
    assign bus_wr   = per_we[0];
    assign stat_wr  = sel_stat & bus_wr;
    assign flush    = sel_ctrl & bus_wr & per_din[2];
    assign tx_busy  = (tx_state != TX_IDLE);
    assign tx_start = sel_data & bus_wr & ~tx_busy;

    // high byte is never written: all registers live in the low byte
    assign unused_din = ^per_din[15:8];

    assign fall = clk_q & ~clk_s[1];
    assign din  = dat_s[1];

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign push  = rx_good & ~full;
    assign pop   = sel_data & bus_rd & ~empty;

    assign irq_rx      = rx_ie & ~empty;
    assign irq_tx      = tx_ie & tx_done;
    assign ps2_clk_oe  = (tx_state == TX_INH);
    assign ps2_data_oe = tx_do;

    // two-flop pad sync, idle-high so reset never fakes a fall
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            clk_s <= 2'b11;
            clk_q <= 1'b1;
            dat_s <= 2'b11;
        end else begin
            clk_s <= {clk_s[0], ps2_clk_i};
            clk_q <= clk_s[1];
            dat_s <= {dat_s[0], ps2_data_i};
        end
    end

    // register read mux, zero when not addressed
    always_comb begin
        per_dout = '0;
        if (reg_sel && bus_rd) begin
            unique case (1'b1)
                sel_stat: per_dout = {8'(level), 1'b0,
                                      tx_done, tx_nack,
                                      rx_err, ovf, tx_busy,
                                      full, ~empty};
                sel_data: per_dout = {8'h00,
                                      empty ? 8'h00
                                            : fifo_mem[rd_ptr]};
                sel_ctrl: per_dout = {14'h0, tx_ie, rx_ie};
                default:  per_dout = '0;
            endcase
        end
    end

    // control bits; flush is a pulse, never stored
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            rx_ie <= 1'b0;
            tx_ie <= 1'b0;
        end else if (sel_ctrl && bus_wr) begin
            rx_ie <= per_din[0];
            tx_ie <= per_din[1];
        end
    end

    // sticky flags: set wins over write-1-to-clear
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            ovf     <= 1'b0;
            rx_err  <= 1'b0;
            tx_nack <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            ovf     <= (ovf & ~(stat_wr & per_din[3]))
                     | (rx_good & full);
            rx_err  <= (rx_err & ~(stat_wr & per_din[4]))
                     | rx_bad;
            tx_nack <= (tx_nack & ~(stat_wr & per_din[5])
                        & ~tx_start)
                     | nack_ack | tx_abort;
            tx_done <= (tx_done & ~(stat_wr & per_din[6])
                        & ~tx_start)
                     | (tx_state == TX_DONE) | tx_abort;
        end
    end

    // fifo pointers and level; flush overrides push and pop
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            if (push && !pop)
                level <= level + LW'(1);
            else if (pop && !push)
                level <= level - LW'(1);
        end
    end

    // fifo storage, no reset needed
    always_ff @(posedge mclk) begin
        if (push)
            fifo_mem[wr_ptr] <= rx_sh;
    end

    // rx state register
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n)
            rx_state <= RX_IDLE;
        else
            rx_state <= rx_next;
    end

    // rx next state, one step per ps2 clock fall
    always_comb begin
        rx_next   = rx_state;
        rx_shift  = 1'b0;
        rx_par_ld = 1'b0;
        rx_good   = 1'b0;
        rx_bad    = 1'b0;
        if (tx_busy) begin
            rx_next = RX_IDLE;
        end else if (to_hit && rx_state != RX_IDLE) begin
            rx_next = RX_IDLE;
            rx_bad  = 1'b1;
        end else if (fall) begin
            unique case (rx_state)
                RX_IDLE: begin
                    if (!din)
                        rx_next = RX_DATA;
                end
                RX_DATA: begin
                    rx_shift = 1'b1;
                    if (rx_cnt == 3'd7)
                        rx_next = RX_PAR;
                end
                RX_PAR: begin
                    rx_par_ld = 1'b1;
                    rx_next   = RX_STOP;
                end
                RX_STOP: begin
                    rx_next = RX_IDLE;
                    if (din && (^{rx_sh, rx_par}))
                        rx_good = 1'b1;
                    else
                        rx_bad = 1'b1;
                end
                default: rx_next = RX_IDLE;
            endcase
        end
    end

    // rx shift register, bit count and parity capture
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            rx_sh  <= '0;
            rx_cnt <= '0;
            rx_par <= 1'b0;
        end else begin
            if (rx_shift) begin
                rx_sh  <= {din, rx_sh[7:1]};
                rx_cnt <= rx_cnt + 3'd1;
            end else if (rx_state == RX_IDLE) begin
                rx_cnt <= '0;
            end
            if (rx_par_ld)
                rx_par <= din;
        end
    end

    // tx state register
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n)
            tx_state <= TX_IDLE;
        else
            tx_state <= tx_next;
    end

    // tx next state; data changes on each fall
    always_comb begin
        tx_next    = tx_state;
        tx_do_nxt  = tx_do;
        tx_shift   = 1'b0;
        tx_cnt_inc = 1'b0;
        nack_ack   = 1'b0;
        tx_abort   = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_do_nxt = 1'b0;
                if (tx_start)
                    tx_next = TX_INH;
            end
            TX_INH: begin
                if (inh_cnt == IW'(INHIBIT_CYC - 1)) begin
                    tx_next   = TX_REQ;
                    tx_do_nxt = 1'b1;
                end
            end
            TX_REQ, TX_SEND: begin
                if (to_hit) begin
                    tx_next   = TX_IDLE;
                    tx_do_nxt = 1'b0;
                    tx_abort  = 1'b1;
                end else if (fall) begin
                    tx_cnt_inc = 1'b1;
                    tx_next    = TX_SEND;
                    if (tx_cnt < 4'd8) begin
                        tx_do_nxt = ~tx_sh[0];
                        tx_shift  = 1'b1;
                    end else if (tx_cnt == 4'd8) begin
                        tx_do_nxt = ~tx_par;
                    end else begin
                        tx_do_nxt = 1'b0;
                        tx_next   = TX_ACK;
                    end
                end
            end
            TX_ACK: begin
                if (to_hit) begin
                    tx_next  = TX_IDLE;
                    tx_abort = 1'b1;
                end else if (fall) begin
                    nack_ack = din;
                    tx_next  = TX_DONE;
                end
            end
            TX_DONE: begin
                tx_next = TX_IDLE;
            end
            default: begin
                tx_next   = TX_IDLE;
                tx_do_nxt = 1'b0;
            end
        endcase
    end

    // tx byte, parity, inhibit timer and fall count
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            tx_sh   <= '0;
            tx_par  <= 1'b0;
            tx_cnt  <= '0;
            inh_cnt <= '0;
            tx_do   <= 1'b0;
        end else begin
            tx_do <= tx_do_nxt;
            if (tx_start) begin
                tx_sh   <= per_din[7:0];
                tx_par  <= ~^per_din[7:0];
                tx_cnt  <= '0;
                inh_cnt <= '0;
            end else begin
                if (tx_state == TX_INH)
                    inh_cnt <= inh_cnt + IW'(1);
                if (tx_shift)
                    tx_sh <= {1'b0, tx_sh[7:1]};
                if (tx_cnt_inc)
                    tx_cnt <= tx_cnt + 4'd1;
            end
        end
    end

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] to_cnt;
    logic          to_run;

    assign to_run = (rx_state != RX_IDLE)
                  | (tx_state == TX_REQ)
                  | (tx_state == TX_SEND)
                  | (tx_state == TX_ACK);
    assign to_hit = to_run & ~fall
                  & (to_cnt == TW'(TIMEOUT_CYC - 1));

    // clock-loss watchdog, restarted by every fall
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n)
            to_cnt <= '0;
        else if (!to_run || fall)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TW'(1);
    end
`else
    logic unused_to;

    assign unused_to = (TIMEOUT_CYC > 0);
    assign to_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_omsp_ps2_fifo.sv
// tb_omsp_ps2_fifo: directed bench, scoreboard queues for bus reads
// and host-to-device bits, checked by separate monitors.
module tb_omsp_ps2_fifo;

    localparam int INH  = 40;
    localparam int TO   = 600;
    localparam int HALF = 8;

    localparam logic [13:0] A_STAT = 14'h0050;
    localparam logic [13:0] A_DATA = 14'h0051;
    localparam logic [13:0] A_CTRL = 14'h0052;

    logic        mclk      = 1'b0;
    logic        puc_rst_n = 1'b1;
    logic [13:0] per_addr  = '0;
    logic [15:0] per_din   = '0;
    logic        per_en    = 1'b0;
    logic [1:0]  per_we    = 2'b00;
    logic [15:0] per_dout;
    logic        irq_rx;
    logic        irq_tx;
    logic        ps2_clk_i;
    logic        ps2_clk_oe;
    logic        ps2_data_i;
    logic        ps2_data_oe;
    logic        dev_clk   = 1'b1;
    logic        dev_data  = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [15:0] rd_q [$];
    string       rd_nm [$];
    logic        rd_mon = 1'b0;
    logic        tx_q [$];
    logic        tx_mon = 1'b0;
    int          tx_bit = 0;

    assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_i = dev_data & ~ps2_data_oe;

    omsp_ps2_fifo #(
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .mclk        (mclk),
        .puc_rst_n   (puc_rst_n),
        .per_addr    (per_addr),
        .per_din     (per_din),
        .per_en      (per_en),
        .per_we      (per_we),
        .per_dout    (per_dout),
        .irq_rx      (irq_rx),
        .irq_tx      (irq_tx),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_i  (ps2_data_i),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 mclk = ~mclk;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic chk(string nm, logic [15:0] act,
                       logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h",
                     nm, act, exp);
        end
    endtask

    // bus read monitor
    always @(negedge mclk) begin
        logic [15:0] e;
        string       n;
        if (rd_mon) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h", per_dout);
            end else begin
                e = rd_q.pop_front();
                n = rd_nm.pop_front();
                chk(n, per_dout, e);
            end
        end
    end

    // host-to-device bit monitor, sampled on device rising edge
    always @(posedge ps2_clk_i) begin
        logic e;
        if (tx_mon) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %b", ps2_data_i);
            end else begin
                e = tx_q.pop_front();
                chk($sformatf("tx_bit%0d", tx_bit),
                    {15'b0, ps2_data_i}, {15'b0, e});
            end
            tx_bit++;
        end
    end

    task automatic wait_cyc(int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic bus_rd(logic [13:0] a, logic [15:0] exp,
                          string nm);
        rd_q.push_back(exp);
        rd_nm.push_back(nm);
        @(posedge mclk);
        #1;
        per_addr = a;
        per_we   = 2'b00;
        per_en   = 1'b1;
        rd_mon   = 1'b1;
        @(posedge mclk);
        #1;
        per_en = 1'b0;
        rd_mon = 1'b0;
    endtask

    task automatic bus_wr(logic [13:0] a, logic [15:0] d);
        @(posedge mclk);
        #1;
        per_addr = a;
        per_din  = d;
        per_we   = 2'b01;
        per_en   = 1'b1;
        @(posedge mclk);
        #1;
        per_en = 1'b0;
        per_we = 2'b00;
    endtask

    task automatic dev_bit(logic b);
        dev_data = b;
        wait_cyc(HALF);
        dev_clk = 1'b0;
        wait_cyc(HALF);
        dev_clk = 1'b1;
    endtask

    task automatic send_frame(logic [7:0] b, logic badpar);
        dev_bit(1'b0);
        for (int i = 0; i < 8; i++)
            dev_bit(b[i]);
        dev_bit((~^b) ^ badpar);
        dev_bit(1'b1);
        dev_data = 1'b1;
        wait_cyc(4);
    endtask

    // device side of a host-to-device frame
    task automatic dev_rx(logic [7:0] b, logic nack);
        int w;
        int n;
        for (int i = 0; i < 8; i++)
            tx_q.push_back(b[i]);
        tx_q.push_back(~^b);
        tx_q.push_back(1'b1);
        w = 0;
        while (ps2_clk_oe !== 1'b1 && w < 200) begin
            @(negedge mclk);
            w++;
        end
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < 10 * INH) begin
            n++;
            @(negedge mclk);
        end
        chk("inhibit_len", 16'(n), 16'(INH));
        chk("start_bit", {15'b0, ps2_data_i}, 16'h0000);
        wait_cyc(HALF);
        tx_bit = 0;
        tx_mon = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            wait_cyc(HALF);
            if (k == 11)
                tx_mon = 1'b0;
            dev_clk = 1'b1;
            wait_cyc(HALF);
            if (k == 10)
                dev_data = nack;
        end
        dev_data = 1'b1;
        wait_cyc(6);
    endtask

    initial begin
        logic [7:0] v;
        int         c;

        #2 puc_rst_n = 1'b0;
        wait_cyc(3);
        chk("reset_pads_irqs",
            {12'h0, ps2_clk_oe, ps2_data_oe, irq_rx, irq_tx},
            16'h0000);
        chk("reset_dout", per_dout, 16'h0000);
        puc_rst_n = 1'b1;
        wait_cyc(2);

        bus_rd(A_STAT, 16'h0000, "reset_status");
        bus_rd(A_CTRL, 16'h0000, "reset_ctrl");
        bus_rd(A_DATA, 16'h0000, "reset_data_empty");
        bus_wr(A_CTRL, 16'h0001);
        bus_rd(A_CTRL, 16'h0001, "ctrl_rx_ie");

        send_frame(8'h1C, 1'b0);
        chk("irq_rx_set", {15'b0, irq_rx}, 16'h0001);
        bus_rd(A_STAT, 16'h0101, "rx1c_status");
        bus_rd(A_DATA, 16'h001C, "rx1c_data");
        bus_rd(A_STAT, 16'h0000, "rx1c_status_after");
        chk("irq_rx_clr", {15'b0, irq_rx}, 16'h0000);

        for (int i = 0; i < 9; i++) begin
            v = 8'h11 * 8'(i + 1);
            send_frame(v, 1'b0);
        end
        bus_rd(A_STAT, 16'h080B, "fifo_full_status");
        for (int i = 0; i < 8; i++) begin
            v = 8'h11 * 8'(i + 1);
            bus_rd(A_DATA, {8'h00, v},
                   $sformatf("fifo_rd%0d", i));
        end
        bus_rd(A_STAT, 16'h0008, "ovf_sticky");
        bus_rd(A_DATA, 16'h0000, "empty_rd");
        bus_wr(A_STAT, 16'h0008);
        bus_rd(A_STAT, 16'h0000, "ovf_clear");

        send_frame(8'h55, 1'b1);
        bus_rd(A_STAT, 16'h0010, "parity_err");
        bus_wr(A_STAT, 16'h0010);
        bus_rd(A_STAT, 16'h0000, "rxerr_clear");

        send_frame(8'h3C, 1'b0);
        send_frame(8'hA5, 1'b0);
        bus_rd(A_STAT, 16'h0201, "two_bytes");
        bus_wr(A_CTRL, 16'h0007);
        bus_rd(A_STAT, 16'h0000, "flush_status");
        bus_rd(A_CTRL, 16'h0003, "flush_selfclr");

        fork
            dev_rx(8'hED, 1'b0);
            begin
                bus_wr(A_DATA, 16'h00ED);
                bus_rd(A_STAT, 16'h0004, "tx_busy");
            end
        join
        bus_rd(A_STAT, 16'h0040, "tx_done");
        chk("irq_tx_set", {15'b0, irq_tx}, 16'h0001);

        fork
            dev_rx(8'h00, 1'b1);
            begin
                bus_wr(A_DATA, 16'h0000);
                bus_wr(A_DATA, 16'h00AA);
                bus_rd(A_STAT, 16'h0004, "tx_busy2");
            end
        join
        bus_rd(A_STAT, 16'h0060, "tx_nack");
        c = 0;
        for (int i = 0; i < 3 * INH; i++) begin
            @(negedge mclk);
            if (ps2_clk_oe)
                c++;
        end
        chk("no_second_tx", 16'(c), 16'h0000);
        bus_wr(A_STAT, 16'h0060);
        bus_rd(A_STAT, 16'h0000, "tx_flags_clear");
        chk("irq_tx_clr", {15'b0, irq_tx}, 16'h0000);

`ifdef PS2_TIMEOUT_EN
        dev_bit(1'b0);
        dev_bit(1'b1);
        dev_bit(1'b0);
        dev_bit(1'b1);
        dev_data = 1'b1;
        wait_cyc(TO + 50);
        bus_rd(A_STAT, 16'h0010, "timeout_rx_err");
        bus_wr(A_STAT, 16'h0010);
        send_frame(8'h1C, 1'b0);
        bus_rd(A_STAT, 16'h0101, "timeout_next_status");
        bus_rd(A_DATA, 16'h001C, "timeout_next_data");
`endif

        wait_cyc(4);
        chk("queues_drained",
            16'(rd_q.size() + tx_q.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
